// File: rtl/video_fb_pixel_writer.sv
// Pixel stream to Avalon-MM single-word frame buffer writer: address calc, clipping, FWFT write FIFO.
// Optional perf counters are enabled with `define VIDEO_FB_PIXEL_WRITER_PERF_EN.
module video_fb_pixel_writer #(
    parameter int RGB_SIZE   = 12,
    parameter int H_SIZE     = 10,
    parameter int V_SIZE     = 10,
    parameter int H_DISPLAY  = 640,
    parameter int V_DISPLAY  = 480,
    parameter int AVN_AW     = 18,
    parameter int AVN_DW     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [H_SIZE-1:0]     pix_hc,
    input  logic [V_SIZE-1:0]     pix_vc,
    input  logic [RGB_SIZE-1:0]   pix_rgb,
    input  logic                  pix_vld,
    output logic                  pix_rdy,
    output logic                  avn_write,
    output logic [AVN_AW-1:0]     avn_address,
    output logic [AVN_DW-1:0]     avn_writedata,
    output logic [AVN_DW/8-1:0]   avn_byteenable,
    input  logic                  avn_waitrequest,
`ifdef VIDEO_FB_PIXEL_WRITER_PERF_EN
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_wr_cnt,
    output logic [31:0]           perf_clip_cnt,
`endif
    output logic                  idle
);

    localparam int FA_W  = H_SIZE + V_SIZE + $clog2(H_DISPLAY) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = AVN_AW + AVN_DW;
    localparam int BE_W  = AVN_DW / 8;

    localparam logic [FA_W-1:0]  H_LIM = FA_W'(H_DISPLAY);
    localparam logic [FA_W-1:0]  V_LIM = FA_W'(V_DISPLAY);
    localparam logic [FA_W-1:0]  A_LIM = {{(FA_W-1){1'b0}}, 1'b1} << AVN_AW;
    localparam logic [CNT_W:0]   OCC_LIM = (CNT_W+1)'(FIFO_DEPTH);

    logic [FA_W-1:0]   full_addr_s;
    logic              clip_s;
    logic [CNT_W:0]    occ_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_empty_s;

    logic              s1_vld_q,  s1_vld_d;
    logic              s1_clip_q, s1_clip_d;
    logic [AVN_AW-1:0] s1_addr_q, s1_addr_d;
    logic [AVN_DW-1:0] s1_data_q, s1_data_d;
    logic              rdy_en_q;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];

    // Address, clip decision, handshake and FIFO control
    always_comb begin
        full_addr_s  = FA_W'(pix_vc) * H_LIM + FA_W'(pix_hc);
        clip_s       = (FA_W'(pix_hc) >= H_LIM) | (FA_W'(pix_vc) >= V_LIM) | (full_addr_s >= A_LIM);
        occ_s        = {1'b0, cnt_q} + {{CNT_W{1'b0}}, s1_vld_q};
        pix_rdy      = rdy_en_q & (occ_s < OCC_LIM);
        accept_s     = pix_vld & pix_rdy;
        fifo_empty_s = (cnt_q == {CNT_W{1'b0}});
        push_s       = s1_vld_q & ~s1_clip_q;
        pop_s        = ~fifo_empty_s & ~avn_waitrequest;
    end

    // Next state for the S1 stage and FIFO bookkeeping
    always_comb begin
        s1_vld_d = accept_s;
        if (accept_s) begin
            s1_clip_d = clip_s;
            s1_addr_d = full_addr_s[AVN_AW-1:0];
            s1_data_d = AVN_DW'(pix_rgb);
        end else begin
            s1_clip_d = s1_clip_q;
            s1_addr_d = s1_addr_q;
            s1_data_d = s1_data_q;
        end
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state; rdy_en_q keeps pix_rdy low until the first clock after reset
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_clip_q <= 1'b0;
            s1_addr_q <= {AVN_AW{1'b0}};
            s1_data_q <= {AVN_DW{1'b0}};
            rdy_en_q  <= 1'b0;
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_clip_q <= s1_clip_d;
            s1_addr_q <= s1_addr_d;
            s1_data_q <= s1_data_d;
            rdy_en_q  <= 1'b1;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // FIFO storage; contents are qualified by cnt_q so no reset is needed
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {s1_addr_q, s1_data_q};
        end
    end

    // First-word fall-through Avalon outputs
    always_comb begin
        avn_write                    = ~fifo_empty_s;
        {avn_address, avn_writedata} = mem_q[rd_ptr_q];
        avn_byteenable               = {BE_W{1'b1}};
        idle                         = ~s1_vld_q & fifo_empty_s;
    end

`ifdef VIDEO_FB_PIXEL_WRITER_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        if (en && (v != 32'hFFFF_FFFF)) begin
            return v + 32'd1;
        end else begin
            return v;
        end
    endfunction

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] wr_cnt_q,    wr_cnt_d;
    logic [31:0] clip_cnt_q,  clip_cnt_d;

    // Saturating performance counter next state
    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, avn_write & avn_waitrequest);
        wr_cnt_d    = sat_inc(wr_cnt_q, pop_s);
        clip_cnt_d  = sat_inc(clip_cnt_q, s1_vld_q & s1_clip_q);
    end

    // Performance counter registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stall_cnt_q <= 32'd0;
            wr_cnt_q    <= 32'd0;
            clip_cnt_q  <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            clip_cnt_q  <= clip_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_wr_cnt    = wr_cnt_q;
    assign perf_clip_cnt  = clip_cnt_q;
`endif

endmodule

// File: tb/tb_video_fb_pixel_writer.sv
// Self-checking bench: directed vector table, backpressure, random streaming scoreboard, async reset.
module tb_video_fb_pixel_writer;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [9:0]  pix_hc;
    logic [9:0]  pix_vc;
    logic [11:0] pix_rgb;
    logic        pix_vld;
    logic        pix_rdy;
    logic        avn_write;
    logic [17:0] avn_address;
    logic [15:0] avn_writedata;
    logic [1:0]  avn_byteenable;
    logic        avn_waitrequest;
    logic        idle;
`ifdef VIDEO_FB_PIXEL_WRITER_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_wr_cnt;
    logic [31:0] perf_clip_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [9:0]  hc;
        logic [9:0]  vc;
        logic [11:0] rgb;
        logic        wr;
        logic [17:0] addr;
        logic [15:0] data;
    } vec_t;

    vec_t vec [8];
    logic [33:0] sb [$];

    video_fb_pixel_writer dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .pix_hc          (pix_hc),
        .pix_vc          (pix_vc),
        .pix_rgb         (pix_rgb),
        .pix_vld         (pix_vld),
        .pix_rdy         (pix_rdy),
        .avn_write       (avn_write),
        .avn_address     (avn_address),
        .avn_writedata   (avn_writedata),
        .avn_byteenable  (avn_byteenable),
        .avn_waitrequest (avn_waitrequest),
`ifdef VIDEO_FB_PIXEL_WRITER_PERF_EN
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_wr_cnt     (perf_wr_cnt),
        .perf_clip_cnt   (perf_clip_cnt),
`endif
        .idle            (idle)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic void model(input logic [9:0] hc, input logic [9:0] vc,
                                  output logic clip, output logic [17:0] addr);
        int fa;
        fa   = int'(vc) * 640 + int'(hc);
        clip = (hc >= 10'd640) || (vc >= 10'd480) || (fa >= 262144);
        addr = fa[17:0];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, nw, n_acc, cyc_cnt, max_occ, w;
        logic rdy_s, prev_clip, new_clip, m_clip;
        logic [17:0] m_addr;
        logic [33:0] e;

        vec[0] = '{10'd5,   10'd2,   12'hABC, 1'b1, 18'd1285,   16'h0ABC};
        vec[1] = '{10'd0,   10'd0,   12'hFFF, 1'b1, 18'd0,      16'h0FFF};
        vec[2] = '{10'd100, 10'd300, 12'h0F0, 1'b1, 18'd192100, 16'h00F0};
        vec[3] = '{10'd640, 10'd0,   12'h111, 1'b0, 18'd0,      16'h0000};
        vec[4] = '{10'd0,   10'd480, 12'h222, 1'b0, 18'd0,      16'h0000};
        vec[5] = '{10'd639, 10'd409, 12'h333, 1'b0, 18'd0,      16'h0000};
        vec[6] = '{10'd383, 10'd409, 12'h555, 1'b1, 18'd262143, 16'h0555};
        vec[7] = '{10'd639, 10'd479, 12'h777, 1'b0, 18'd0,      16'h0000};

        pix_hc = 10'd0; pix_vc = 10'd0; pix_rgb = 12'd0; pix_vld = 1'b0;
        avn_waitrequest = 1'b0;

        #12;
        chk("rst_write", 64'(avn_write), 64'd0);
        chk("rst_idle",  64'(idle),      64'd1);
        chk("rst_rdy",   64'(pix_rdy),   64'd0);
        cyc();
        sys_rst_n = 1'b1;
        cyc();
        cyc();

        // Directed single pixels from idle
        for (int i = 0; i < 8; i++) begin
            pix_hc = vec[i].hc; pix_vc = vec[i].vc; pix_rgb = vec[i].rgb; pix_vld = 1'b1;
            chk($sformatf("v%0d_rdy", i), 64'(pix_rdy), 64'd1);
            cyc();
            pix_vld = 1'b0;
            chk($sformatf("v%0d_early", i), 64'(avn_write), 64'd0);
            cyc();
            chk($sformatf("v%0d_write", i), 64'(avn_write), 64'(vec[i].wr));
            if (vec[i].wr) begin
                chk($sformatf("v%0d_addr", i), 64'(avn_address),    64'(vec[i].addr));
                chk($sformatf("v%0d_data", i), 64'(avn_writedata),  64'(vec[i].data));
                chk($sformatf("v%0d_be", i),   64'(avn_byteenable), 64'd3);
            end
            cyc();
            chk($sformatf("v%0d_idle", i),  64'(idle),      64'd1);
            chk($sformatf("v%0d_after", i), 64'(avn_write), 64'd0);
        end

        // Backpressure: FIFO fills, head held stable
        acc = 0;
        avn_waitrequest = 1'b1;
        pix_vld = 1'b1;
        for (int c = 0; c < 20; c++) begin
            pix_hc = 10'(acc); pix_vc = 10'd0; pix_rgb = 12'(acc * 3 + 1);
            rdy_s = pix_rdy;
            if (avn_write) chk("bp_head", 64'(avn_address), 64'd0);
            cyc();
            if (rdy_s) acc++;
        end
        chk("bp_accepted", 64'(acc),         64'd8);
        chk("bp_rdy_low",  64'(pix_rdy),     64'd0);
        chk("bp_write",    64'(avn_write),   64'd1);
        chk("bp_head_end", 64'(avn_address), 64'd0);
`ifdef VIDEO_FB_PIXEL_WRITER_PERF_EN
        chk("perf_stall", 64'(perf_stall_cnt), 64'd18);
        chk("perf_wr_a",  64'(perf_wr_cnt),    64'd4);
        chk("perf_clip",  64'(perf_clip_cnt),  64'd4);
`endif
        pix_vld = 1'b0;
        avn_waitrequest = 1'b0;
        nw = 0;
        for (int c = 0; c < 30 && nw < 8; c++) begin
            if (avn_write) begin
                chk($sformatf("bp_addr%0d", nw), 64'(avn_address),   64'(nw));
                chk($sformatf("bp_data%0d", nw), 64'(avn_writedata), 64'(nw * 3 + 1));
                nw++;
            end
            cyc();
        end
        chk("bp_writes",  64'(nw),      64'd8);
        chk("bp_rdy_end", 64'(pix_rdy), 64'd1);
        chk("bp_idle",    64'(idle),    64'd1);
`ifdef VIDEO_FB_PIXEL_WRITER_PERF_EN
        chk("perf_wr_b",  64'(perf_wr_cnt), 64'd12);
`endif

        // Random streaming against a scoreboard
        n_acc = 0; cyc_cnt = 0; max_occ = 0; prev_clip = 1'b0;
        while (n_acc < 1000 && cyc_cnt < 20000) begin
            pix_vld = 1'($urandom_range(0, 1));
            pix_hc  = 10'($urandom_range(0, 700));
            pix_vc  = 10'($urandom_range(0, 500));
            pix_rgb = 12'($urandom);
            avn_waitrequest = 1'($urandom_range(0, 1));
            chk("st_rdy", 64'(pix_rdy), 64'(((sb.size() + int'(prev_clip)) < 8) ? 1 : 0));
            if (avn_write && !avn_waitrequest) begin
                if (sb.size() == 0) begin
                    chk("st_spurious_wr", 64'(avn_write), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("st_wr", 64'({avn_address, avn_writedata}), 64'(e));
                end
            end
            new_clip = 1'b0;
            if (pix_vld && pix_rdy) begin
                model(pix_hc, pix_vc, m_clip, m_addr);
                n_acc++;
                if (m_clip) new_clip = 1'b1;
                else sb.push_back({m_addr, 4'h0, pix_rgb});
            end
            prev_clip = new_clip;
            if (sb.size() > max_occ) max_occ = sb.size();
            cyc();
            cyc_cnt++;
        end
        pix_vld = 1'b0;
        avn_waitrequest = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (avn_write) begin
                if (sb.size() == 0) begin
                    chk("st_extra_wr", 64'(avn_write), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("st_drain", 64'({avn_address, avn_writedata}), 64'(e));
                end
            end
            cyc();
        end
        chk("st_count",    64'(n_acc),              64'd1000);
        chk("st_leftover", 64'(sb.size()),          64'd0);
        chk("st_idle",     64'(idle),               64'd1);
        chk("st_no_ovf",   64'(max_occ <= 8 ? 1 : 0), 64'd1);

        // Asynchronous reset with 5 buffered entries
        avn_waitrequest = 1'b1;
        pix_vld = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pix_hc = 10'(20 + k); pix_vc = 10'd0; pix_rgb = 12'h0AA;
            cyc();
        end
        pix_vld = 1'b0;
        cyc();
        chk("ar_pre_write", 64'(avn_write), 64'd1);
        #3;
        sys_rst_n = 1'b0;
        #1;
        chk("ar_write", 64'(avn_write), 64'd0);
        chk("ar_idle",  64'(idle),      64'd1);
        chk("ar_rdy",   64'(pix_rdy),   64'd0);
        cyc();
        sys_rst_n = 1'b1;
        avn_waitrequest = 1'b0;
`ifdef VIDEO_FB_PIXEL_WRITER_PERF_EN
        chk("perf_rst", 64'(perf_stall_cnt | perf_wr_cnt | perf_clip_cnt), 64'd0);
`endif
        for (int c = 0; c < 3; c++) begin
            chk("ar_no_stale", 64'(avn_write), 64'd0);
            cyc();
        end
        pix_hc = 10'd1; pix_vc = 10'd0; pix_rgb = 12'h456; pix_vld = 1'b1;
        w = 0;
        while (!pix_rdy && w < 10) begin cyc(); w++; end
        chk("ar_rdy_back", 64'(pix_rdy), 64'd1);
        cyc();
        pix_vld = 1'b0;
        w = 0;
        while (!avn_write && w < 10) begin cyc(); w++; end
        chk("ar_first_wr",   64'(avn_write),     64'd1);
        chk("ar_first_addr", 64'(avn_address),   64'd1);
        chk("ar_first_data", 64'(avn_writedata), 64'h0456);
        cyc();
        chk("ar_end_idle", 64'(idle), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
